// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, tag/source encodings and the CDB entry type for the common data bus arbiter.
// Optional same-edge bypass is selected by the CDB_BYPASS_EN macro (see cdb_arbiter.sv).
package cdb_arbiter_pkg;

    localparam int ROB_TAG_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int TAG_W         = ROB_TAG_WIDTH;
    localparam int DATA_W        = DATA_WIDTH;

    localparam logic [TAG_W-1:0] ZERO_TAG = '0;
    localparam logic             SRC_ALU  = 1'b0;
    localparam logic             SRC_SLB  = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              ioin;
    } cdb_entry_t;

    // Round-robin pick: a tie goes to the source that did not broadcast last.
    function automatic logic pick_src(input logic alu_cand, input logic slb_cand,
                                      input logic last_grant);
        if (alu_cand && slb_cand)
            return (last_grant == SRC_SLB) ? SRC_ALU : SRC_SLB;
        else if (alu_cand)
            return SRC_ALU;
        else
            return SRC_SLB;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer/consumer bundle of the CDB arbiter; clk, rst and rdy stay plain ports.
// Shared by the default build and the CDB_BYPASS_EN build.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    // Producers present a nonzero tag for exactly one cycle per result; there is no
    // backpressure, so they watch out_*_full and out_overflow records any lost push.
    logic              in_misbranch;
    logic [TAG_W-1:0]  in_alu_tag;
    logic [DATA_W-1:0] in_alu_value;
    logic [TAG_W-1:0]  in_slb_tag;
    logic [DATA_W-1:0] in_slb_value;
    logic              in_slb_ioin;
    logic              out_alu_full;
    logic              out_slb_full;
    logic [TAG_W-1:0]  out_cdb_tag;
    logic [DATA_W-1:0] out_cdb_value;
    logic              out_cdb_ioin;
    logic              out_cdb_src;
    logic              out_overflow;
    logic              out_dbg_last_grant;

    modport master (
        output in_misbranch, in_alu_tag, in_alu_value, in_slb_tag, in_slb_value, in_slb_ioin,
        input  out_alu_full, out_slb_full, out_cdb_tag, out_cdb_value, out_cdb_ioin,
               out_cdb_src, out_overflow, out_dbg_last_grant
    );

    modport slave (
        input  in_misbranch, in_alu_tag, in_alu_value, in_slb_tag, in_slb_value, in_slb_ioin,
        output out_alu_full, out_slb_full, out_cdb_tag, out_cdb_value, out_cdb_ioin,
               out_cdb_src, out_overflow, out_dbg_last_grant
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO with flush and a sticky overflow flag; full uses the registered count.
// Used unchanged whether or not CDB_BYPASS_EN is defined.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic       i_push,
    input  cdb_entry_t i_data,
    input  logic       i_pop,
    output cdb_entry_t o_head,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_head     = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

    // A pop in the same cycle does not make room: a push at full is always dropped.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_en) begin
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (i_push && o_full)
                    r_overflow <= 1'b1;
                if (w_do_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_do_push && !w_do_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_do_push && w_do_pop)
                    r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_en && !i_flush && w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus from the ALU and SLB FIFOs.
// Define CDB_BYPASS_EN to let a push into an empty FIFO broadcast at the same edge.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    cdb_arbiter_if.slave  bus
);

    cdb_entry_t r_cdb;
    logic       r_src;
    logic       r_last_grant;

    cdb_entry_t w_alu_in_entry, w_slb_in_entry;
    cdb_entry_t w_alu_head, w_slb_head;
    cdb_entry_t w_win_entry;
    logic       w_alu_in, w_slb_in;
    logic       w_alu_empty, w_slb_empty;
    logic       w_alu_full, w_slb_full;
    logic       w_alu_ovf, w_slb_ovf;
    logic       w_alu_cand, w_slb_cand;
    logic       w_any, w_grant;
    logic       w_alu_pop, w_slb_pop;
    logic       w_alu_byp, w_slb_byp;
    logic       w_alu_push, w_slb_push;

    assign w_alu_in       = (bus.in_alu_tag != ZERO_TAG);
    assign w_slb_in       = (bus.in_slb_tag != ZERO_TAG);
    assign w_alu_in_entry = '{tag: bus.in_alu_tag, value: bus.in_alu_value, ioin: 1'b0};
    assign w_slb_in_entry = '{tag: bus.in_slb_tag, value: bus.in_slb_value, ioin: bus.in_slb_ioin};

    always_comb begin
        w_alu_cand = ~w_alu_empty;
        w_slb_cand = ~w_slb_empty;
`ifdef CDB_BYPASS_EN
        w_alu_cand = w_alu_cand | w_alu_in;
        w_slb_cand = w_slb_cand | w_slb_in;
`endif
        w_any   = w_alu_cand | w_slb_cand;
        w_grant = pick_src(w_alu_cand, w_slb_cand, r_last_grant);

        w_alu_pop = w_any & (w_grant == SRC_ALU) & ~w_alu_empty;
        w_slb_pop = w_any & (w_grant == SRC_SLB) & ~w_slb_empty;
`ifdef CDB_BYPASS_EN
        w_alu_byp = w_any & (w_grant == SRC_ALU) & w_alu_empty;
        w_slb_byp = w_any & (w_grant == SRC_SLB) & w_slb_empty;
`else
        w_alu_byp = 1'b0;
        w_slb_byp = 1'b0;
`endif
        // A bypassed result goes straight to the bus and never occupies a FIFO slot.
        w_alu_push = w_alu_in & ~w_alu_byp;
        w_slb_push = w_slb_in & ~w_slb_byp;

        if (w_grant == SRC_ALU)
            w_win_entry = w_alu_empty ? w_alu_in_entry : w_alu_head;
        else
            w_win_entry = w_slb_empty ? w_slb_in_entry : w_slb_head;
    end

    cdb_src_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_en       (rdy),
        .i_flush    (bus.in_misbranch),
        .i_push     (w_alu_push),
        .i_data     (w_alu_in_entry),
        .i_pop      (w_alu_pop),
        .o_head     (w_alu_head),
        .o_empty    (w_alu_empty),
        .o_full     (w_alu_full),
        .o_overflow (w_alu_ovf)
    );

    cdb_src_fifo #(.DEPTH(DEPTH)) u_slb_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_en       (rdy),
        .i_flush    (bus.in_misbranch),
        .i_push     (w_slb_push),
        .i_data     (w_slb_in_entry),
        .i_pop      (w_slb_pop),
        .o_head     (w_slb_head),
        .o_empty    (w_slb_empty),
        .o_full     (w_slb_full),
        .o_overflow (w_slb_ovf)
    );

    // Idle and flush cycles only clear the tag; value, ioin and src keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb        <= '0;
            r_src        <= SRC_ALU;
            r_last_grant <= SRC_SLB;
        end else if (rdy) begin
            if (bus.in_misbranch) begin
                r_cdb.tag <= ZERO_TAG;
            end else if (w_any) begin
                r_cdb        <= w_win_entry;
                r_src        <= w_grant;
                r_last_grant <= w_grant;
            end else begin
                r_cdb.tag <= ZERO_TAG;
            end
        end
    end

    assign bus.out_cdb_tag        = r_cdb.tag;
    assign bus.out_cdb_value      = r_cdb.value;
    assign bus.out_cdb_ioin       = r_cdb.ioin;
    assign bus.out_cdb_src        = r_src;
    assign bus.out_alu_full       = w_alu_full;
    assign bus.out_slb_full       = w_slb_full;
    assign bus.out_overflow       = w_alu_ovf | w_slb_ovf;
    assign bus.out_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue reference model feeds an expected queue checked every cycle.
// Follows CDB_BYPASS_EN when that macro is defined for the build.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int W     = TAG_W + DATA_W + 5;

    logic clk;
    logic rst;
    logic rdy;

    cdb_arbiter_if bus ();

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    cdb_entry_t   m_a[$];
    cdb_entry_t   m_s[$];
    cdb_entry_t   m_cdb;
    logic         m_src;
    logic         m_last;
    logic         m_ovf;

    function automatic logic [W-1:0] got_vec();
        return {bus.out_cdb_tag, bus.out_cdb_value, bus.out_cdb_ioin, bus.out_cdb_src,
                bus.out_alu_full, bus.out_slb_full, bus.out_overflow};
    endfunction

    // Drive one cycle, advance the reference model, push the expected bus state.
    task automatic cycle(input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                         input logic [TAG_W-1:0] st, input logic [DATA_W-1:0] sv,
                         input logic si, input logic mb, input logic rd, input logic rs);
        int         pre_a, pre_s;
        logic       ca, cs, byp_a, byp_s;
        cdb_entry_t ent;
        rst = rs; rdy = rd;
        bus.in_misbranch = mb;
        bus.in_alu_tag = at; bus.in_alu_value = av;
        bus.in_slb_tag = st; bus.in_slb_value = sv; bus.in_slb_ioin = si;
        if (rs) begin
            m_a.delete(); m_s.delete();
            m_cdb = '0; m_src = 1'b0; m_last = 1'b1; m_ovf = 1'b0;
        end else if (rd) begin
            if (mb) begin
                m_a.delete(); m_s.delete();
                m_cdb.tag = '0;
            end else begin
                pre_a = m_a.size(); pre_s = m_s.size();
                ca = (pre_a != 0); cs = (pre_s != 0);
`ifdef CDB_BYPASS_EN
                ca = ca | (at != 0); cs = cs | (st != 0);
`endif
                byp_a = 1'b0; byp_s = 1'b0;
                if (ca && (!cs || m_last == 1'b1)) begin
                    if (pre_a != 0) ent = m_a.pop_front();
                    else begin ent = '{tag: at, value: av, ioin: 1'b0}; byp_a = 1'b1; end
                    m_cdb = ent; m_src = 1'b0; m_last = 1'b0;
                end else if (cs) begin
                    if (pre_s != 0) ent = m_s.pop_front();
                    else begin ent = '{tag: st, value: sv, ioin: si}; byp_s = 1'b1; end
                    m_cdb = ent; m_src = 1'b1; m_last = 1'b1;
                end else begin
                    m_cdb.tag = '0;
                end
                if (at != 0 && !byp_a) begin
                    if (pre_a == DEPTH) m_ovf = 1'b1;
                    else m_a.push_back('{tag: at, value: av, ioin: 1'b0});
                end
                if (st != 0 && !byp_s) begin
                    if (pre_s == DEPTH) m_ovf = 1'b1;
                    else m_s.push_back('{tag: st, value: sv, ioin: si});
                end
            end
        end
        exp_q.push_back({m_cdb.tag, m_cdb.value, m_cdb.ioin, m_src,
                         (m_a.size() == DEPTH), (m_s.size() == DEPTH), m_ovf});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        e = exp_q.pop_front(); g = got_vec(); checks++;
        if (g !== e) begin errors++; $display("FAIL reset_state got %h exp %h", g, e); end
        checks++;
        if (bus.out_cdb_tag !== 5'd0 || bus.out_overflow !== 1'b0 || bus.out_cdb_value !== 32'd0) begin
            errors++; $display("FAIL reset_zero got tag %0d ovf %b", bus.out_cdb_tag, bus.out_overflow);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cycle(5'd3, 32'h11, 0, 0, 0, 0, 1, 0);
            else        cycle(0, 0, 0, 0, 0, 0, 1, 0);
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL single step %0d got %h exp %h", i, g, e); end
`ifdef CDB_BYPASS_EN
            if (i == 0) begin
`else
            if (i == 1) begin
`endif
                checks++;
                if (bus.out_cdb_tag !== 5'd3 || bus.out_cdb_value !== 32'h11 || bus.out_cdb_src !== 1'b0) begin
                    errors++; $display("FAIL single_latency got tag %0d value %h src %b exp 3 11 0",
                                       bus.out_cdb_tag, bus.out_cdb_value, bus.out_cdb_src);
                end
            end
        end
    endtask

    task automatic test_tie();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       cycle(5'd4, 32'hA4, 5'd5, 32'h55, 1'b1, 0, 1, 0);
                3:       cycle(5'd6, 32'hA6, 5'd8, 32'h58, 1'b0, 0, 1, 0);
                default: cycle(0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL tie step %0d got %h exp %h", i, g, e); end
        end
    endtask

    task automatic test_full_overflow();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       cycle(5'd1, 32'h101, 5'd10, 32'h210, 1'b0, 0, 1, 0);
                1:       cycle(5'd2, 32'h102, 5'd11, 32'h211, 1'b1, 0, 1, 0);
                2:       cycle(5'd9, 32'h109, 0, 0, 0, 0, 1, 0);
                3:       cycle(5'd13, 32'h113, 0, 0, 0, 0, 1, 0);
                default: cycle(0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL full_ovf step %0d got %h exp %h", i, g, e); end
        end
`ifndef CDB_BYPASS_EN
        checks++;
        if (bus.out_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky got %b exp 1", bus.out_overflow);
        end
`endif
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        e = exp_q.pop_front(); g = got_vec(); checks++;
        if (g !== e) begin errors++; $display("FAIL overflow_clear got %h exp %h", g, e); end
    endtask

    task automatic test_misbranch();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       cycle(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 0, 1, 0);
                1:       cycle(5'd3, 32'h3, 5'd4, 32'h4, 1'b0, 0, 1, 0);
                2:       cycle(5'd5, 32'h5, 0, 0, 0, 0, 1, 0);
                3:       cycle(5'd7, 32'h77, 0, 0, 0, 1, 1, 0);
                5:       cycle(5'd8, 32'h8, 5'd9, 32'h9, 1'b1, 0, 1, 0);
                default: cycle(0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL misbranch step %0d got %h exp %h", i, g, e); end
            if (i == 3) begin
                checks++;
                if (bus.out_cdb_tag !== 5'd0 || bus.out_alu_full !== 1'b0 || bus.out_slb_full !== 1'b0) begin
                    errors++; $display("FAIL misbranch_flush got tag %0d full %b%b exp 0 00",
                                       bus.out_cdb_tag, bus.out_alu_full, bus.out_slb_full);
                end
            end
        end
    endtask

    task automatic test_rdy_low();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 10; i++) begin
            case (i)
                0:          cycle(5'd1, 32'hC1, 5'd2, 32'hC2, 1'b1, 0, 1, 0);
                1:          cycle(5'd3, 32'hC3, 0, 0, 0, 0, 1, 0);
                2, 3, 4:    cycle(5'd9, 32'hC9, 5'd10, 32'hCA, 1'b0, 1, 0, 0);
                default:    cycle(0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL rdy_low step %0d got %h exp %h", i, g, e); end
        end
    endtask

    task automatic test_reset_midway();
        logic [W-1:0] e, g;
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       cycle(5'd1, 32'hD1, 5'd2, 32'hD2, 1'b0, 0, 1, 0);
                1:       cycle(5'd3, 32'hD3, 0, 0, 0, 0, 1, 0);
                2:       cycle(5'd5, 32'hD5, 5'd6, 32'hD6, 1'b1, 0, 0, 1);
                3:       cycle(5'd7, 32'hD7, 5'd8, 32'hD8, 1'b1, 0, 1, 0);
                default: cycle(0, 0, 0, 0, 0, 0, 1, 0);
            endcase
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL rst_mid step %0d got %h exp %h", i, g, e); end
            if (i == 2) begin
                checks++;
                if (g !== '0) begin errors++; $display("FAIL rst_mid_zero got %h exp 0", g); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]      e, g;
        logic [TAG_W-1:0]  at, st;
        logic              mb, rd, rs;
        for (int i = 0; i < 400; i++) begin
            at = ($urandom_range(0, 2) == 0) ? 5'd0 : TAG_W'($urandom_range(1, 31));
            st = ($urandom_range(0, 2) == 0) ? 5'd0 : TAG_W'($urandom_range(1, 31));
            mb = ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 99) == 0);
            cycle(at, 32'($urandom), st, 32'($urandom), 1'($urandom_range(0, 1)), mb, rd, rs);
            e = exp_q.pop_front(); g = got_vec(); checks++;
            if (g !== e) begin errors++; $display("FAIL random step %0d got %h exp %h", i, g, e); end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0;
        bus.in_misbranch = 1'b0;
        bus.in_alu_tag = '0; bus.in_alu_value = '0;
        bus.in_slb_tag = '0; bus.in_slb_value = '0; bus.in_slb_ioin = 1'b0;
        m_cdb = '0; m_src = 1'b0; m_last = 1'b1; m_ovf = 1'b0;
        #2;
        test_reset();
        test_single();
        test_tie();
        test_full_overflow();
        test_misbranch();
        test_rdy_low();
        test_reset_midway();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
